i2s_frame_ctrl: RTL and testbench
=================================

I2S_FRAME_CTRL -- requirements
Module: i2s_frame_ctrl

Interface
REQ-001 Parameters: none; slot width comes from frame_size at run time.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 sclk  in  1  serial bit clock; all state changes on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 en  in  1  stream enable; deassertion is a graceful stop request.
REQ-006 frame_size  in  frame_size_t  f16bits = 16-bit slot, f32bits = 32-bit slot.
REQ-007 stereo  in  1  1 = L+R data; 0 = data in LEFT only.
REQ-008 tx_empty  in  1  Tx FIFO empty flag, read side.
REQ-009 rx_full  in  1  Rx FIFO full flag, write side.
REQ-010 clr_err  in  1  clears the sticky error flags.
REQ-011 ws  out  1  word select: 0 = left, 1 = right.
REQ-012 tx_rd_en  out  1  Tx FIFO serial-read enable.
REQ-013 rx_wr_en  out  1  Rx FIFO serial-write enable.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 bit_idx  out  5  current bit index, counting down from MSB.
REQ-016 underrun  out  1  sticky: Tx slot skipped.
REQ-017 overrun  out  1  sticky: Rx slot skipped.

Function
REQ-018 States (ctrl_state_t): IDLE, PRIME, LEFT, RIGHT.
REQ-019 Transitions:
- IDLE->PRIME when en=1.
- PRIME->LEFT after exactly 1 cycle.
- LEFT->RIGHT when bit_idx=0.
- RIGHT->LEFT when bit_idx=0 and en=1.
- RIGHT->IDLE when bit_idx=0 and en=0.
REQ-020 en=0 during PRIME or LEFT shall not abort the frame; the stop takes effect only at the RIGHT->IDLE boundary.
REQ-021 maxp is 15 for f16bits and 31 for f32bits; frame_size and stereo are latched on entry to LEFT and held for the whole frame.
REQ-022 Bit counter:
- loads maxp on entry to LEFT or RIGHT;
- decrements by 1 per cycle in LEFT and RIGHT;
- equals 0 in IDLE and PRIME;
- bit_idx always shows the counter value.
REQ-023 Each slot lasts exactly maxp+1 cycles; a full frame lasts 2*(maxp+1) cycles.
REQ-024 ws is registered and leads the slot by one cycle (I2S):
- ws=0 in PRIME and in LEFT while bit_idx>0;
- ws=1 in LEFT at bit_idx=0;
- ws=1 in RIGHT while bit_idx>0;
- ws=0 in RIGHT at bit_idx=0 if continuing;
- ws=1 at that point if stopping, and ws=1 in IDLE.
REQ-025 Slot qualification is decided on the first cycle of each slot:
- tx_ok = !tx_empty;
- rx_ok = !rx_full.
REQ-026 tx_rd_en is high for the whole slot iff tx_ok and (LEFT, or RIGHT with stereo=1); otherwise it is low for the whole slot.
REQ-027 rx_wr_en follows the same rule as tx_rd_en, using rx_ok.
REQ-028 Both enables are always low in IDLE and PRIME, and never toggle mid-slot.
REQ-029 underrun sets when a qualifying slot has tx_ok=0; overrun sets when a qualifying slot has rx_ok=0.
REQ-030 clr_err=1 clears both flags; if a set event occurs in the same cycle, the set wins.

Reset
REQ-031 While rst=1:
- state=IDLE, bit counter=0, ws=1;
- tx_rd_en=0, rx_wr_en=0, busy=0;
- underrun=0, overrun=0;
- latched frame_size = f32bits, latched stereo = 1.
REQ-032 rst=1 mid-slot shall abort immediately; both enables are low from the next edge.

Structure
REQ-033 ctrl_pkg shall own ctrl_state_t, frame_size_t and the constants MAXP16=15 and MAXP32=31.
REQ-034 One sub-module, slot_counter, shall provide the loadable down-counter with a zero flag; all other logic lives in i2s_frame_ctrl.

Verification
REQ-035 Reset, then en=1, f32bits, stereo=1, FIFOs ready -> PRIME 1 cycle; ws falls; tx_rd_en high for 32 cycles, ws=1 on the 32nd; RIGHT enables high 32 cycles.
REQ-036 f16bits, stereo=0 -> LEFT enables high for 16 cycles; RIGHT enables low for 16 cycles; frame period 32 cycles.
REQ-037 tx_empty=1 at start of LEFT -> tx_rd_en low for the whole slot; underrun=1 from the next cycle; rx_wr_en unaffected.
REQ-038 en dropped at bit_idx=20 of LEFT (f32bits) -> remaining 20 LEFT cycles plus 32 RIGHT cycles complete; then IDLE; ws=1 and busy=0.
REQ-039 clr_err and an overrun event in the same cycle -> overrun stays 1; clr_err alone on the next cycle -> 0.
REQ-040 rst=1 at bit_idx=7 of RIGHT -> on the next edge state=IDLE, enables=0, ws=1, bit_idx=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and slot-length constants for the I2S frame controller
package ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, LEFT, RIGHT} ctrl_state_t;
  typedef enum logic {f16bits, f32bits} frame_size_t;
  localparam logic [4:0] MAXP16 = 5'd15;
  localparam logic [4:0] MAXP32 = 5'd31;
  function automatic logic [4:0] maxp(input frame_size_t fs);
    return fs == f32bits ? MAXP32 : MAXP16;
  endfunction
endpackage

// File: rtl/i2s_frame_ctrl_if.sv
// i2s_frame_ctrl_if: stream control, FIFO flags and frame timing outputs
interface i2s_frame_ctrl_if;
  import ctrl_pkg::*;
  logic en;
  frame_size_t frame_size;
  logic stereo;
  logic tx_empty;
  logic rx_full;
  logic clr_err;
  logic ws;
  logic tx_rd_en;
  logic rx_wr_en;
  logic busy;
  logic [4:0] bit_idx;
  logic underrun;
  logic overrun;
  modport master (
    input en, frame_size, stereo, tx_empty, rx_full, clr_err,
    output ws, tx_rd_en, rx_wr_en, busy, bit_idx, underrun, overrun
  );
  modport slave (
    output en, frame_size, stereo, tx_empty, rx_full, clr_err,
    input ws, tx_rd_en, rx_wr_en, busy, bit_idx, underrun, overrun
  );
endinterface

// File: rtl/slot_counter.sv
// slot_counter: loadable down-counter with zero flag and look-ahead value
module slot_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic [4:0] cnt,
  output logic [4:0] cnt_nxt,
  output logic       zero
);
  assign cnt_nxt = load ? load_val : cnt - 5'd1;
  assign zero = cnt == 5'd0;
  always_ff @(posedge clk) begin
    if (rst) cnt <= 5'd0;
    else cnt <= cnt_nxt;
  end
endmodule

// File: rtl/i2s_frame_ctrl.sv
// i2s_frame_ctrl: I2S frame sequencer driving word select and FIFO slot enables
module i2s_frame_ctrl
  import ctrl_pkg::*;
(
  input logic sclk,
  input logic rst,
  i2s_frame_ctrl_if.master bus
);
  ctrl_state_t state, state_n;
  frame_size_t fs_q;
  logic st_q, ws_q, ws_n, first_q, tx_q, rx_q, und_q, ovr_q;
  logic load, zero, in_slot, nxt_slot, qual;
  logic [4:0] cnt, cnt_nxt, load_val;
  assign in_slot = state == LEFT || state == RIGHT;
  assign nxt_slot = state_n == LEFT || state_n == RIGHT;
  assign load = state_n != state || !nxt_slot;
  assign load_val = !nxt_slot ? 5'd0 : state_n == LEFT ? maxp(bus.frame_size) : maxp(fs_q);
  assign qual = state == LEFT || (state == RIGHT && st_q);
  slot_counter u_cnt (
    .clk(sclk),
    .rst,
    .load,
    .load_val,
    .cnt,
    .cnt_nxt,
    .zero
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.en ? PRIME : IDLE;
      PRIME:   state_n = LEFT;
      LEFT:    state_n = zero ? RIGHT : LEFT;
      RIGHT:   state_n = zero ? (bus.en ? LEFT : IDLE) : RIGHT;
      default: state_n = IDLE;
    endcase
  end
  // ws is registered one slot-bit early, so it is derived from the next state/count
  always_comb begin
    ws_n = 1'b1;
    case (state_n)
      PRIME:   ws_n = 1'b0;
      LEFT:    ws_n = cnt_nxt == 5'd0;
      RIGHT:   ws_n = cnt_nxt != 5'd0 || !bus.en;
      default: ws_n = 1'b1;
    endcase
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= IDLE;
      fs_q <= f32bits;
      st_q <= 1'b1;
      ws_q <= 1'b1;
      first_q <= 1'b0;
      tx_q <= 1'b0;
      rx_q <= 1'b0;
      und_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == LEFT && state != LEFT) begin
        fs_q <= bus.frame_size;
        st_q <= bus.stereo;
      end
      ws_q <= ws_n;
      first_q <= nxt_slot && state_n != state;
      if (first_q) begin
        tx_q <= qual && !bus.tx_empty;
        rx_q <= qual && !bus.rx_full;
      end
      und_q <= (first_q && qual && bus.tx_empty) || (und_q && !bus.clr_err);
      ovr_q <= (first_q && qual && bus.rx_full) || (ovr_q && !bus.clr_err);
    end
  end
  // slot decision is taken live on the first cycle, then held from the latch
  assign bus.tx_rd_en = in_slot && (first_q ? qual && !bus.tx_empty : tx_q);
  assign bus.rx_wr_en = in_slot && (first_q ? qual && !bus.rx_full : rx_q);
  assign bus.ws = ws_q;
  assign bus.busy = state != IDLE;
  assign bus.bit_idx = cnt;
  assign bus.underrun = und_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// tb_i2s_frame_ctrl: table-driven frame vectors with a per-cycle scoreboard
module tb_i2s_frame_ctrl;
  import ctrl_pkg::*;
  typedef struct packed {
    logic busy, ws, tx, rx;
    logic [4:0] idx;
    logic und, ovr;
  } obs_t;
  typedef struct {
    frame_size_t fs;
    logic st, txe_l, txe_r, rxf_l, rxf_r;
    int exp_tx, exp_rx;
  } vec_t;
  logic sclk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0, act_tx = 0, act_rx = 0;
  logic m_und = 1'b0, m_ovr = 1'b0;
  obs_t sbq[$];
  obs_t m_ex, m_act;
  vec_t vt[6];
  vec_t hv;
  i2s_frame_ctrl_if bus ();
  i2s_frame_ctrl dut (.sclk(sclk), .rst(rst), .bus(bus));
  always #5 sclk = ~sclk;
  always @(negedge sclk) begin
    if (sbq.size() > 0) begin
      m_ex = sbq.pop_front();
      m_act = {bus.busy, bus.ws, bus.tx_rd_en, bus.rx_wr_en, bus.bit_idx, bus.underrun, bus.overrun};
      act_tx += int'(m_act.tx);
      act_rx += int'(m_act.rx);
      checks++;
      if (m_act !== m_ex) begin
        failures++;
        $display("FAIL cycle t=%0t busy/ws/tx/rx/idx/und/ovr got %b %b %b %b %0d %b %b want %b %b %b %b %0d %b %b",
                 $time, m_act.busy, m_act.ws, m_act.tx, m_act.rx, m_act.idx, m_act.und, m_act.ovr,
                 m_ex.busy, m_ex.ws, m_ex.tx, m_ex.rx, m_ex.idx, m_ex.und, m_ex.ovr);
      end
    end
  end
  function automatic obs_t mk(input logic b, w, t, r, input logic [4:0] i);
    return {b, w, t, r, i, m_und, m_ovr};
  endfunction
  task automatic cyc(input logic r, e, input frame_size_t fs, input logic st, txe, rxf, clr, input obs_t ex);
    @(posedge sclk);
    #1;
    rst = r;
    bus.en = e;
    bus.frame_size = fs;
    bus.stereo = st;
    bus.tx_empty = txe;
    bus.rx_full = rxf;
    bus.clr_err = clr;
    sbq.push_back(ex);
  endtask
  task automatic drain();
    for (int k = 0; k < 4 && sbq.size() > 0; k++) begin
      @(negedge sclk);
      #1;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
      sbq.delete();
    end
  endtask
  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) begin
      cyc(r, 1'b0, f32bits, 1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0));
      if (r) begin
        m_und = 1'b0;
        m_ovr = 1'b0;
      end
    end
    drain();
  endtask
  task automatic start(input frame_size_t fs, input logic st);
    cyc(1'b0, 1'b1, fs, st, 1'b0, 1'b0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0));
    cyc(1'b0, 1'b1, fs, st, 1'b0, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0));
    drain();
  endtask
  task automatic frame(input vec_t v, input frame_size_t nfs, input logic nst, input logic stop,
                       input int drop, input int clr_at, input int abort_at);
    int mp, n, btx, brx;
    logic first, qual, last, txs, rxs, txe, rxf, e, clr, ws;
    frame_size_t ofs;
    mp = v.fs == f32bits ? 31 : 15;
    ofs = v.fs == f32bits ? f16bits : f32bits;
    n = 0;
    btx = act_tx;
    brx = act_rx;
    for (int s = 0; s < 2; s++) begin
      for (int i = mp; i >= 0; i--) begin
        first = i == mp;
        last = s == 1 && i == 0;
        qual = s == 0 || v.st;
        txs = s == 1 ? v.txe_r : v.txe_l;
        rxs = s == 1 ? v.rxf_r : v.rxf_l;
        txe = first ? txs : logic'($urandom_range(0, 1));
        rxf = first ? rxs : logic'($urandom_range(0, 1));
        e = !(stop && ((s == 1 && i <= 1) || (drop >= 0 && (s == 1 || i <= drop))));
        clr = clr_at >= 0 && (n == clr_at || n == clr_at + 1);
        ws = s == 0 ? i == 0 : (i != 0 || stop);
        cyc(n == abort_at, e, last ? nfs : ofs, last ? nst : !v.st, txe, rxf, clr,
            mk(1'b1, ws, qual && !txs, qual && !rxs, 5'(i)));
        m_und = (first && qual && txs) || (m_und && !clr);
        m_ovr = (first && qual && rxs) || (m_ovr && !clr);
        if (n == abort_at) begin
          m_und = 1'b0;
          m_ovr = 1'b0;
          drain();
          return;
        end
        n++;
      end
    end
    drain();
    if (v.exp_tx >= 0) begin
      checks += 2;
      if (act_tx - btx != v.exp_tx) begin
        failures++;
        $display("FAIL tx_count got %0d want %0d", act_tx - btx, v.exp_tx);
      end
      if (act_rx - brx != v.exp_rx) begin
        failures++;
        $display("FAIL rx_count got %0d want %0d", act_rx - brx, v.exp_rx);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0] = '{f32bits, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64, 64};
    vt[1] = '{f16bits, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16};
    vt[2] = '{f32bits, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32, 64};
    vt[3] = '{f16bits, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32, 16};
    vt[4] = '{f16bits, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16, 16};
    vt[5] = '{f32bits, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    bus.en = 1'b0;
    bus.frame_size = f32bits;
    bus.stereo = 1'b1;
    bus.tx_empty = 1'b0;
    bus.rx_full = 1'b0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge sclk);
    idle(2, 1'b1);
    idle(2, 1'b0);
    start(vt[0].fs, vt[0].st);
    for (int k = 0; k < 6; k++)
      frame(vt[k], k < 5 ? vt[k + 1].fs : f32bits, k < 5 ? vt[k + 1].st : 1'b1, k == 5, -1, -1, -1);
    idle(2, 1'b0);
    hv = '{f32bits, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64, 64};
    start(f32bits, 1'b1);
    frame(hv, f32bits, 1'b1, 1'b1, 20, -1, -1);
    idle(2, 1'b0);
    hv = '{f16bits, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32, 16};
    start(f16bits, 1'b1);
    frame(hv, f32bits, 1'b1, 1'b0, -1, 16, -1);
    hv = '{f32bits, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1};
    frame(hv, f32bits, 1'b1, 1'b0, -1, -1, 56);
    idle(3, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
